// File: rtl/mul_div_seq.sv
// Sequential signed multiply (Booth) / divide (restoring) unit with Y operand register.
// Define MULDIV_BOOTH_RADIX4_EN for bit-pair Booth multiply (16 iterations instead of 32).
module mul_div_seq (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] BusMuxOut,
  input  logic        Yin,
  input  logic        start,
  input  logic        op,
  output logic [31:0] ZHI,
  output logic [31:0] ZLO,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

`ifdef MULDIV_BOOTH_RADIX4_EN
  localparam logic [5:0] MUL_ITERS = 6'd16;
`else
  localparam logic [5:0] MUL_ITERS = 6'd32;
`endif
  localparam logic [5:0] DIV_ITERS = 6'd32;

  logic [1:0]  r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_y;
  logic [34:0] r_a;
  logic [31:0] r_q;
  logic        r_qm1;
  logic [31:0] r_m;
  logic        r_op;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [31:0] r_zhi;
  logic [31:0] r_zlo;
  logic        r_div_zero;

  logic        w_start_ok;
  logic        w_div0;
  logic [31:0] w_y_abs;
  logic [31:0] w_b_abs;
  logic [34:0] w_m_ext;
  logic [34:0] w_booth_sum;
  logic [34:0] w_mul_a;
  logic [31:0] w_mul_q;
  logic        w_mul_qm1;
  logic [34:0] w_rem_sh;
  logic [34:0] w_trial;
  logic [34:0] w_div_a;
  logic [31:0] w_div_q;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_start_ok = (r_state == S_IDLE) && start;
  assign w_div0     = op && (BusMuxOut == 32'd0);
  assign w_y_abs    = r_y[31] ? (32'd0 - r_y) : r_y;
  assign w_b_abs    = BusMuxOut[31] ? (32'd0 - BusMuxOut) : BusMuxOut;
  assign w_m_ext    = {{3{r_m[31]}}, r_m};

  // Accumulator is 35 bits wide so +/-2M on a 0x80000000 multiplicand never overflows.
  always_comb begin
    w_booth_sum = r_a;
`ifdef MULDIV_BOOTH_RADIX4_EN
    case ({r_q[1:0], r_qm1})
      3'b001, 3'b010: w_booth_sum = r_a + w_m_ext;
      3'b011:         w_booth_sum = r_a + (w_m_ext << 1);
      3'b100:         w_booth_sum = r_a - (w_m_ext << 1);
      3'b101, 3'b110: w_booth_sum = r_a - w_m_ext;
      default:        w_booth_sum = r_a;
    endcase
    w_mul_a   = {{2{w_booth_sum[34]}}, w_booth_sum[34:2]};
    w_mul_q   = {w_booth_sum[1:0], r_q[31:2]};
    w_mul_qm1 = r_q[1];
`else
    case ({r_q[0], r_qm1})
      2'b01:   w_booth_sum = r_a + w_m_ext;
      2'b10:   w_booth_sum = r_a - w_m_ext;
      default: w_booth_sum = r_a;
    endcase
    w_mul_a   = {w_booth_sum[34], w_booth_sum[34:1]};
    w_mul_q   = {w_booth_sum[0], r_q[31:1]};
    w_mul_qm1 = r_q[0];
`endif
  end

  // Restoring step: shift next dividend bit into the remainder, keep trial if no borrow.
  assign w_rem_sh = {r_a[33:0], r_q[31]};
  assign w_trial  = w_rem_sh - {3'b000, r_m};
  assign w_div_a  = w_trial[34] ? w_rem_sh : w_trial;
  assign w_div_q  = {r_q[30:0], ~w_trial[34]};

  assign w_quot = r_neg_q ? (32'd0 - r_q) : r_q;
  assign w_rem  = r_neg_r ? (32'd0 - r_a[31:0]) : r_a[31:0];

  always_ff @(posedge clock) begin
    if (clear) begin
      r_y <= 32'd0;
    end else if (Yin) begin
      r_y <= BusMuxOut;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= w_div0 ? S_DONE : S_CALC;
            r_cnt   <= (op ? DIV_ITERS : MUL_ITERS) - 6'd1;
          end
        end
        S_CALC: begin
          if (r_cnt == 6'd0) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt - 6'd1;
          end
        end
        S_FIX:   r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_a     <= 35'd0;
      r_q     <= 32'd0;
      r_qm1   <= 1'b0;
      r_m     <= 32'd0;
      r_op    <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_start_ok) begin
      r_a   <= 35'd0;
      r_qm1 <= 1'b0;
      r_op  <= op;
      if (op) begin
        r_q     <= w_y_abs;
        r_m     <= w_b_abs;
        r_neg_q <= r_y[31] ^ BusMuxOut[31];
        r_neg_r <= r_y[31];
      end else begin
        r_q     <= BusMuxOut;
        r_m     <= r_y;
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
      end
    end else if (r_state == S_CALC) begin
      if (r_op) begin
        r_a <= w_div_a;
        r_q <= w_div_q;
      end else begin
        r_a   <= w_mul_a;
        r_q   <= w_mul_q;
        r_qm1 <= w_mul_qm1;
      end
    end
  end

  // Results only change on the edge entering DONE; an aborted operation writes nothing.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_zhi      <= 32'd0;
      r_zlo      <= 32'd0;
      r_div_zero <= 1'b0;
    end else if (w_start_ok && w_div0) begin
      r_zhi      <= r_y;
      r_zlo      <= 32'hFFFF_FFFF;
      r_div_zero <= 1'b1;
    end else if (r_state == S_FIX) begin
      r_div_zero <= 1'b0;
      if (r_op) begin
        r_zhi <= w_rem;
        r_zlo <= w_quot;
      end else begin
        r_zhi <= r_a[31:0];
        r_zlo <= r_q;
      end
    end
  end

  assign ZHI      = r_zhi;
  assign ZLO      = r_zlo;
  assign div_zero = r_div_zero;
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_mul_div_seq.sv
// Randomized self-checking bench for mul_div_seq against a plain-arithmetic reference.
module tb_mul_div_seq;

`ifdef MULDIV_BOOTH_RADIX4_EN
  localparam int MUL_LAT = 18;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] BusMuxOut;
  logic        Yin;
  logic        start;
  logic        op;
  logic [31:0] ZHI;
  logic [31:0] ZLO;
  logic        busy;
  logic        done;
  logic        div_zero;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  mul_div_seq dut (
    .clock    (clock),
    .clear    (clear),
    .BusMuxOut(BusMuxOut),
    .Yin      (Yin),
    .start    (start),
    .op       (op),
    .ZHI      (ZHI),
    .ZLO      (ZLO),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p;
  endfunction

  // Returns {remainder, quotient}; SV '/' and '%' already truncate toward zero.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd0;
      3:       return 32'($urandom_range(0, 20));
      4:       return 32'd0 - 32'($urandom_range(1, 20));
      default: return $urandom();
    endcase
  endfunction

  // a must equal the Y register contents when load_y is 0.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic opv,
                       input bit load_y, input int inject_at, input int clear_at,
                       input string tag);
    logic [63:0] expv;
    int lat;
    int cnt;
    bit aborted;
    aborted = 1'b0;
    if (load_y) begin
      BusMuxOut = a;
      Yin = 1'b1;
      @(posedge clock); #1;
      Yin = 1'b0;
    end
    expv = opv ? ref_div(a, b) : ref_mul(a, b);
    lat  = !opv ? MUL_LAT : (b == 32'd0 ? 1 : DIV_LAT);
    BusMuxOut = b;
    op = opv;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cnt = 1;
    while (!done && cnt < 200 && !aborted) begin
      if (cnt == 1) begin
        check({tag, " busy"}, 64'(busy), 64'd1);
        check({tag, " held"}, {ZHI, ZLO}, {exp_hi, exp_lo});
      end
      if (cnt == inject_at) begin
        Yin = 1'b1;
        BusMuxOut = 32'h1234;
        start = 1'b1;
      end
      if (cnt == clear_at) clear = 1'b1;
      @(posedge clock); #1;
      cnt++;
      Yin = 1'b0;
      start = 1'b0;
      if (clear) begin
        clear = 1'b0;
        aborted = 1'b1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        check({tag, " clr out"}, {ZHI, ZLO}, 64'd0);
        check({tag, " clr flags"}, {61'd0, busy, done, div_zero}, 64'd0);
      end
    end
    if (!aborted) begin
      check({tag, " latency"}, 64'(cnt), 64'(lat));
      check({tag, " result"}, {ZHI, ZLO}, expv);
      check({tag, " div_zero"}, 64'(div_zero), 64'(opv && b == 32'd0));
      exp_hi = expv[63:32];
      exp_lo = expv[31:0];
      @(posedge clock); #1;
      check({tag, " done pulse"}, {62'd0, done, busy}, 64'd0);
    end
  endtask

  initial begin
    clear = 1'b1;
    BusMuxOut = 32'hDEAD_BEEF;
    Yin = 1'b1;
    start = 1'b1;
    op = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset out", {ZHI, ZLO}, 64'd0);
    check("reset flags", {61'd0, busy, done, div_zero}, 64'd0);
    clear = 1'b0;
    Yin = 1'b0;
    start = 1'b0;

    // Y was held at 0 by clear despite Yin=1
    do_op(32'd0, 32'd9, 1'b0, 1'b0, 0, 0, "y reset");
    do_op(32'd7, 32'hFFFF_FFFD, 1'b0, 1'b1, 0, 0, "mul 7*-3");
    do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 0, 0, "mul min*min");
    do_op(32'hFFFF_FFEF, 32'd5, 1'b1, 1'b1, 0, 0, "div -17/5");
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 0, 0, "div min/-1");
    do_op(32'd100, 32'd0, 1'b1, 1'b1, 0, 0, "div 100/0");
    do_op(32'd6, 32'd7, 1'b0, 1'b1, 0, 0, "mul after div0");

    do_op(32'h0001_1111, 32'h0000_2345, 1'b0, 1'b1, 10, 0, "mul inject");
    do_op(32'h1234, 32'd2, 1'b0, 1'b0, 0, 0, "y after inject");

    do_op(32'd1000, 32'd7, 1'b1, 1'b1, 0, 5, "div clear");
    do_op(32'd3, 32'd4, 1'b0, 1'b1, 0, 0, "mul 3*4");

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      logic o;
      a = pick();
      b = pick();
      o = 1'($urandom_range(0, 1));
      do_op(a, b, o, 1'b1, 0, 0, o ? "rand div" : "rand mul");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_seq.md
MUL_DIV_SEQ -- requirements
Module: mul_div_seq

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, rising edge; clear  in  1  synchronous active-high reset.
REQ-002 SHALL have ports: BusMuxOut  in  32  bus value from the 32:1 bus multiplexer; Yin  in  1  load Y operand register from BusMuxOut.
REQ-003 SHALL have ports: start  in  1  begin operation, B operand = BusMuxOut this cycle; op  in  1  0=signed multiply, 1=signed divide.
REQ-004 SHALL have ports: ZHI  out  32  high result / remainder; ZLO  out  32  low result / quotient; these drive the bus mux ZHI/ZLO inputs.
REQ-005 SHALL have ports: busy  out  1  operation in flight; done  out  1  one-cycle completion pulse; div_zero  out  1  last divide had zero divisor.
REQ-006 SHALL use one clock; reset is synchronous and active-high, via port clear.

Function
REQ-007 SHALL hold 32-bit register Y; Yin=1 at an edge loads BusMuxOut, in any state.
REQ-008 SHALL accept start only in IDLE; at that edge copy A=Y (pre-edge value) and B=BusMuxOut into internal registers, then enter CALC.
REQ-009 SHALL ignore start while busy=1; Yin during an operation SHALL NOT affect the in-flight operands.
REQ-010 SHALL implement FSM IDLE -> CALC -> FIX -> DONE -> IDLE; CALC performs one iteration per cycle; FIX applies sign correction; DONE lasts exactly one cycle.
REQ-011 SHALL assert busy in CALC, FIX, DONE; done=1 only in DONE.
REQ-012 Multiply SHALL produce ZHI:ZLO = signed 64-bit A*B, Booth recoded, exact for all inputs including 0x80000000.
REQ-013 Divide SHALL use restoring division on magnitudes, 32 iterations; ZLO = quotient truncated toward zero, ZHI = remainder with sign of dividend.
REQ-014 0x80000000 / 0xFFFFFFFF SHALL yield ZLO=0x80000000, ZHI=0, div_zero=0.
REQ-015 Divide with B=0 SHALL go IDLE -> DONE directly, set ZLO=0xFFFFFFFF, ZHI=A, div_zero=1.
REQ-016 Latency counted in rising edges from and including the start edge to the edge entering DONE: CALC iterations + 2 (radix-2 multiply and divide = 34); divide-by-zero = 1.
REQ-017 ZHI/ZLO SHALL keep prior values until updated on the edge entering DONE; div_zero updates on that same edge for every operation (0 for multiply).
REQ-018 A start accepted on the edge leaving DONE is not possible; start is sampled only while in IDLE (state register value).

Reset
REQ-019 clear=1 at an edge SHALL force IDLE and Y=0, ZHI=0, ZLO=0, busy=0, done=0, div_zero=0, overriding Yin and start.
REQ-020 clear mid-operation SHALL abort with no result written; next start after clear deasserts SHALL behave as from power-up.

Configuration
REQ-021 Macro MULDIV_BOOTH_RADIX4_EN defined: multiply SHALL use bit-pair (radix-4) Booth recoding, 16 CALC cycles, latency 18.
REQ-022 Macro MULDIV_BOOTH_RADIX4_EN undefined: multiply SHALL use radix-2 Booth, 32 CALC cycles, latency 34; divide behaviour identical in both builds.

Verification
REQ-023 Y=7, start op=0 B=0xFFFFFFFD -> after latency ZHI=0xFFFFFFFF, ZLO=0xFFFFFFEB, done one cycle, div_zero=0.
REQ-024 Y=0x80000000, multiply B=0x80000000 -> ZHI=0x40000000, ZLO=0x00000000; check both macro builds (latency 34 / 18).
REQ-025 Y=0xFFFFFFEF (-17), divide B=5 -> ZLO=0xFFFFFFFD, ZHI=0xFFFFFFFE after 34 edges; Y=0x80000000, B=0xFFFFFFFF -> ZLO=0x80000000, ZHI=0.
REQ-026 Y=100, divide B=0 -> done after 1 edge, ZLO=0xFFFFFFFF, ZHI=0x00000064, div_zero=1.
REQ-027 Start multiply, at CALC cycle 10 pulse Yin=1 with bus=0x1234 and start=1 -> result uses original operands, second start ignored, Y=0x1234 after.
REQ-028 Start divide, assert clear at CALC cycle 5 -> next cycle all outputs 0, state IDLE; new multiply 3*4 then yields ZLO=12, ZHI=0.
